// File: rtl/pkt_arbiter.sv
// Packet arbiter feeding usb_comm: buffered trace traffic has priority, two aux sources share idle slots round-robin.
// Optional PKT_ARB_HWM_EN builds the trace FIFO occupancy high-water-mark tracker; otherwise fifo_hwm reads 0.
module pkt_arbiter #(
    parameter int          FIFO_LOG2 = 4,
    parameter logic [15:0] CFG_ADDR  = 16'h0002
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic [15:0]          config_addr,
    input  logic [15:0]          config_data,
    input  logic                 config_strobe,
    input  logic [31:0]          trace_data,
    input  logic                 trace_strobe,
    input  logic [31:0]          aux0_data,
    input  logic                 aux0_valid,
    output logic                 aux0_ready,
    input  logic [31:0]          aux1_data,
    input  logic                 aux1_valid,
    output logic                 aux1_ready,
    input  logic                 out_full,
    output logic [31:0]          packet_data,
    output logic                 packet_strobe,
    output logic [15:0]          overflow_count,
    output logic [FIFO_LOG2:0]   fifo_hwm
);
    localparam int               DEPTH   = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2+1)'(DEPTH);

    logic [31:0]          mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic [15:0]          drops;
    logic                 pending;
    logic [2:0]           cfg;
    logic                 rr;

    logic        has_room, push_trace, drop, push_marker, do_push;
    logic        fifo_empty, pop, aux_slot, req0, req1, clr;
    logic [31:0] wr_word;

    // Room is judged on the pre-pop count, so a full FIFO drops even while draining.
    assign has_room    = count < DEPTH_C;
    assign push_trace  = trace_strobe && has_room;
    assign drop        = trace_strobe && !has_room;
    assign push_marker = pending && has_room && !trace_strobe;
    assign do_push     = push_trace || push_marker;
    assign wr_word     = push_trace ? trace_data : {16'hFFFE, drops};

    assign fifo_empty  = (count == '0);
    assign pop         = !out_full && !fifo_empty;
    assign aux_slot    = !out_full && fifo_empty;
    assign req0        = aux0_valid && cfg[0];
    assign req1        = aux1_valid && cfg[1];
    assign aux0_ready  = aux_slot && req0 && (!req1 || !rr);
    assign aux1_ready  = aux_slot && req1 && (!req0 || rr);
    assign clr         = cfg[2];

    always_ff @(posedge mclk) begin
        if (do_push) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            drops          <= '0;
            pending        <= 1'b0;
            cfg            <= 3'b011;
            rr             <= 1'b0;
            packet_strobe  <= 1'b0;
            packet_data    <= '0;
            overflow_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FIFO_LOG2+1)'(do_push) - (FIFO_LOG2+1)'(pop);

            if (aux0_ready || aux1_ready) rr <= !rr;

            packet_strobe <= pop || aux0_ready || aux1_ready;
            if (pop)             packet_data <= mem[rd_ptr];
            else if (aux0_ready) packet_data <= aux0_data;
            else if (aux1_ready) packet_data <= aux1_data;

            // Clear bit is a one-cycle pulse; enables persist.
            if (config_strobe && config_addr == CFG_ADDR) cfg <= config_data[2:0];
            else                                          cfg[2] <= 1'b0;

            if (clr) begin
                overflow_count <= '0;
                drops          <= '0;
                pending        <= 1'b0;
            end else if (drop) begin
                if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
                if (drops != 16'hFFFF)          drops          <= drops + 16'd1;
                pending <= 1'b1;
            end else if (push_marker) begin
                drops   <= '0;
                pending <= 1'b0;
            end
        end
    end

`ifdef PKT_ARB_HWM_EN
    logic [FIFO_LOG2:0] hwm;
    always_ff @(posedge mclk or posedge reset) begin
        if (reset)            hwm <= '0;
        else if (clr)         hwm <= '0;
        else if (count > hwm) hwm <= count;
    end
    assign fifo_hwm = hwm;
`else
    assign fifo_hwm = '0;
`endif

endmodule
